// File: rtl/frame_buffer_fetch_engine.sv
// Cache-line fetch engine: turns one line request into per-beat DDR read commands,
// reassembles the returned beats and presents the finished line for one cycle.
module frame_buffer_fetch_engine #(
  parameter int ADDR_WIDTH     = 28,
  parameter int APP_DATA_WIDTH = 128,
  parameter int BLOCK_WORDS    = 16,
  parameter int ADDR_STEP      = 8
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      req_strobe,
  input  logic [ADDR_WIDTH-1:0]     req_addr,
  input  logic [7:0]                req_count,
  output logic                      app_en,
  output logic [2:0]                app_cmd,
  output logic [ADDR_WIDTH-1:0]     app_addr,
  input  logic                      app_rdy,
  input  logic [APP_DATA_WIDTH-1:0] app_rd_data,
  input  logic                      app_rd_data_valid,
  output logic                      rd_valid,
  output logic [ADDR_WIDTH-1:0]     rd_addr,
  output logic [BLOCK_WORDS*32-1:0] rd_data,
  output logic                      busy
);
  localparam int LINE_W    = BLOCK_WORDS * 32;
  localparam int MAX_BEATS = LINE_W / APP_DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, CMD, DRAIN, DONE} state_t;
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [2:0]            beats;
  } req_t;

  state_t            state, state_nxt;
  req_t              cur, pend, new_req, next_req;
  logic              pend_vld, new_vld, next_vld;
  logic [2:0]        issued, received;
  logic [LINE_W-1:0] line, line_nxt;
  logic              cmd_fire, beat_fire, cmds_done, data_done;

  assign new_req.addr  = req_addr;
  assign new_req.beats = (req_count > 8'(MAX_BEATS)) ? 3'(MAX_BEATS) : req_count[2:0];
  assign new_vld       = req_strobe && (req_count != 8'd0);
  // A strobe landing in the DONE cycle supersedes the pending slot.
  assign next_req      = req_strobe ? new_req : pend;
  assign next_vld      = req_strobe ? new_vld : pend_vld;

  assign cmd_fire  = (state == CMD) && app_rdy;
  assign beat_fire = ((state == CMD) || (state == DRAIN)) && app_rd_data_valid &&
                     (received != cur.beats);
  assign cmds_done = (state == DRAIN) || (cmd_fire && (issued + 3'd1 == cur.beats));
  assign data_done = (received == cur.beats) || (beat_fire && (received + 3'd1 == cur.beats));

  assign app_en   = (state == CMD);
  assign app_cmd  = 3'b001;
  assign app_addr = cur.addr + ADDR_WIDTH'(issued) * ADDR_WIDTH'(ADDR_STEP);
  assign rd_valid = (state == DONE);
  assign busy     = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (new_vld) state_nxt = CMD;
      CMD:     if (cmds_done) state_nxt = data_done ? DONE : DRAIN;
      DRAIN:   if (data_done) state_nxt = DONE;
      DONE:    state_nxt = next_vld ? CMD : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Unwritten beat slots keep the previous line's data for short requests.
  always_comb begin
    line_nxt = line;
    for (int k = 0; k < MAX_BEATS; k++)
      if (beat_fire && (received == 3'(k)))
        line_nxt[k*APP_DATA_WIDTH +: APP_DATA_WIDTH] = app_rd_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      cur      <= '0;
      pend     <= '0;
      pend_vld <= 1'b0;
      issued   <= '0;
      received <= '0;
      line     <= '0;
      rd_addr  <= '0;
      rd_data  <= '0;
    end else begin
      state <= state_nxt;
      line  <= line_nxt;
      if (cmd_fire)  issued   <= issued + 3'd1;
      if (beat_fire) received <= received + 3'd1;
      if ((state == IDLE) && new_vld) begin
        cur      <= new_req;
        issued   <= '0;
        received <= '0;
      end
      if (state == DONE) begin
        pend_vld <= 1'b0;
        if (next_vld) begin
          cur      <= next_req;
          issued   <= '0;
          received <= '0;
        end
      end else if ((state != IDLE) && req_strobe) begin
        pend     <= new_req;
        pend_vld <= new_vld;
      end
      if ((state_nxt == DONE) && (state != DONE)) begin
        rd_addr <= cur.addr;
        rd_data <= line_nxt;
      end
    end
  end
endmodule
